// File: rtl/semaforo_pkg.sv
`default_nettype none
// ============================================================================
// semaforo_pkg : state encoding and default phase durations for the crossing
// Rev 1.0
// ============================================================================
package semaforo_pkg;

    typedef enum logic [3:0] {
        VERDE_A    = 4'd0,
        AMARILLO_A = 4'd1,
        ROJO_1     = 4'd2,
        VERDE_B    = 4'd3,
        AMARILLO_B = 4'd4,
        ROJO_2     = 4'd5,
        PEATON     = 4'd6
    } estado_t;

    localparam int unsigned T_VERDE_DEF     = 8;
    localparam int unsigned T_AMARILLO_DEF  = 3;
    localparam int unsigned T_TODO_ROJO_DEF = 1;
    localparam int unsigned T_PEATON_DEF    = 6;
    localparam int unsigned CNT_W_DEF       = 4;

endpackage
`default_nettype wire

// File: rtl/semaforo_cruce_ctrl_if.sv
`default_nettype none
// ============================================================================
// semaforo_cruce_ctrl_if : request inputs and lamp/status outputs of the crossing
// Rev 1.0
// ============================================================================
interface semaforo_cruce_ctrl_if;

    logic       IN;
    logic       Sensor;
    logic       Rojo_A;
    logic       Amarillo_A;
    logic       Verde_A;
    logic       Rojo_B;
    logic       Amarillo_B;
    logic       Verde_B;
    logic       Pasar_Persona;
    logic       Peticion_Pendiente;
    logic [3:0] Estado;

    modport master (
        output IN, Sensor,
        input  Rojo_A, Amarillo_A, Verde_A,
        input  Rojo_B, Amarillo_B, Verde_B,
        input  Pasar_Persona, Peticion_Pendiente, Estado
    );

    modport slave (
        input  IN, Sensor,
        output Rojo_A, Amarillo_A, Verde_A,
        output Rojo_B, Amarillo_B, Verde_B,
        output Pasar_Persona, Peticion_Pendiente, Estado
    );

endinterface
`default_nettype wire

// File: rtl/temporizador.sv
`default_nettype none
// ============================================================================
// temporizador : down counter with synchronous load, saturating at zero
// Rev 1.0
// ============================================================================
module temporizador #(
    parameter int unsigned      CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             carga,
    input  wire logic [CNT_W-1:0] valor,
    output logic                  fin
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (carga) begin
            cnt_d = valor;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fin = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/semaforo_cruce_ctrl.sv
`default_nettype none
// ============================================================================
// semaforo_cruce_ctrl : Moore sequencer for a two-road crossing with walk phase
// Rev 1.0
// ============================================================================
module semaforo_cruce_ctrl
    import semaforo_pkg::*;
#(
    parameter int unsigned T_VERDE     = T_VERDE_DEF,
    parameter int unsigned T_AMARILLO  = T_AMARILLO_DEF,
    parameter int unsigned T_TODO_ROJO = T_TODO_ROJO_DEF,
    parameter int unsigned T_PEATON    = T_PEATON_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  wire logic           clk,
    input  wire logic           rst,
    semaforo_cruce_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] C_CARGA_VERDE    = CNT_W'(T_VERDE - 1);
    localparam logic [CNT_W-1:0] C_CARGA_AMARILLO = CNT_W'(T_AMARILLO - 1);
    localparam logic [CNT_W-1:0] C_CARGA_ROJO     = CNT_W'(T_TODO_ROJO - 1);
    localparam logic [CNT_W-1:0] C_CARGA_PEATON   = CNT_W'(T_PEATON - 1);

    estado_t          state_q;
    estado_t          state_d;
    logic             car_pend_q;
    logic             car_pend_d;
    logic             ped_pend_q;
    logic             ped_pend_d;
    logic             fin;
    logic             carga;
    logic [CNT_W-1:0] valor;

    temporizador #(
        .CNT_W   (CNT_W),
        .RST_VAL (C_CARGA_VERDE)
    ) u_temporizador (
        .clk   (clk),
        .rst   (rst),
        .carga (carga),
        .valor (valor),
        .fin   (fin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= VERDE_A;
            car_pend_q <= 1'b0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            car_pend_q <= car_pend_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    // Unlisted codes fall to the default and restart at VERDE_A.
    always_comb begin
        state_d = state_q;
        case (state_q)
            VERDE_A:    if (fin && (car_pend_q || ped_pend_q)) state_d = AMARILLO_A;
            AMARILLO_A: if (fin) state_d = ROJO_1;
            ROJO_1:     if (fin) state_d = ped_pend_q ? PEATON : VERDE_B;
            PEATON:     if (fin) state_d = car_pend_q ? VERDE_B : VERDE_A;
            VERDE_B:    if (fin) state_d = AMARILLO_B;
            AMARILLO_B: if (fin) state_d = ROJO_2;
            ROJO_2:     if (fin) state_d = VERDE_A;
            default:    state_d = VERDE_A;
        endcase
    end

    always_comb begin
        carga = (state_d != state_q);
        case (state_d)
            VERDE_A, VERDE_B:       valor = C_CARGA_VERDE;
            AMARILLO_A, AMARILLO_B: valor = C_CARGA_AMARILLO;
            ROJO_1, ROJO_2:         valor = C_CARGA_ROJO;
            PEATON:                 valor = C_CARGA_PEATON;
            default:                valor = C_CARGA_VERDE;
        endcase
    end

    // Clearing on the entry edge takes priority over a request seen that cycle.
    always_comb begin
        car_pend_d = car_pend_q;
        ped_pend_d = ped_pend_q;
        if (bus.Sensor && (state_q != VERDE_B) && (state_q != AMARILLO_B)) begin
            car_pend_d = 1'b1;
        end
        if (bus.IN && (state_q != PEATON)) begin
            ped_pend_d = 1'b1;
        end
        if ((state_d == VERDE_B) && (state_q != VERDE_B)) begin
            car_pend_d = 1'b0;
        end
        if ((state_d == PEATON) && (state_q != PEATON)) begin
            ped_pend_d = 1'b0;
        end
    end

    logic w_verde_a;
    logic w_amarillo_a;
    logic w_verde_b;
    logic w_amarillo_b;

    assign w_verde_a    = (state_q == VERDE_A);
    assign w_amarillo_a = (state_q == AMARILLO_A);
    assign w_verde_b    = (state_q == VERDE_B);
    assign w_amarillo_b = (state_q == AMARILLO_B);

    assign bus.Verde_A            = w_verde_a;
    assign bus.Amarillo_A         = w_amarillo_a;
    assign bus.Rojo_A             = ~(w_verde_a | w_amarillo_a);
    assign bus.Verde_B            = w_verde_b;
    assign bus.Amarillo_B         = w_amarillo_b;
    assign bus.Rojo_B             = ~(w_verde_b | w_amarillo_b);
    assign bus.Pasar_Persona      = (state_q == PEATON);
    assign bus.Peticion_Pendiente = ped_pend_q;
    assign bus.Estado             = state_q;

endmodule
`default_nettype wire

// File: tb/tb_semaforo_cruce_ctrl.sv
`default_nettype none
// ============================================================================
// tb_semaforo_cruce_ctrl : table vectors, corner sequences and random run
// Rev 1.0
// ============================================================================
module tb_semaforo_cruce_ctrl;

    logic clk;
    logic rst;

    semaforo_cruce_ctrl_if bus ();

    semaforo_cruce_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase, cycles spent in it, pending requests.
    int m_phase;
    int m_el;
    bit m_car;
    bit m_ped;

    typedef struct {
        int scen;
        int estado;
        int len;
    } seg_t;

    seg_t segs[$];
    int   in_cyc[3];
    int   sen_cyc[3];

    logic [6:0] dut_lamps;
    assign dut_lamps = {bus.Rojo_A, bus.Amarillo_A, bus.Verde_A,
                        bus.Rojo_B, bus.Amarillo_B, bus.Verde_B, bus.Pasar_Persona};

    function automatic int dur(int ph);
        case (ph)
            0, 3:    return 8;
            1, 4:    return 3;
            2, 5:    return 1;
            6:       return 6;
            default: return 1;
        endcase
    endfunction

    function automatic logic [6:0] lamps_of(int ph);
        logic va, aa, vb, ab;
        va = (ph == 0);
        aa = (ph == 1);
        vb = (ph == 3);
        ab = (ph == 4);
        return {!(va || aa), aa, va, !(vb || ab), ab, vb, (ph == 6)};
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_el    = 0;
        m_car   = 1'b0;
        m_ped   = 1'b0;
    endtask

    task automatic model_step(input bit in, input bit sen);
        int nxt;
        bit fin;
        nxt = m_phase;
        fin = (m_el >= dur(m_phase) - 1);
        case (m_phase)
            0: if (fin && (m_car || m_ped)) nxt = 1;
            1: if (fin) nxt = 2;
            2: if (fin) nxt = m_ped ? 6 : 3;
            6: if (fin) nxt = m_car ? 3 : 0;
            3: if (fin) nxt = 4;
            4: if (fin) nxt = 5;
            5: if (fin) nxt = 0;
            default: nxt = 0;
        endcase
        if (sen && m_phase != 3 && m_phase != 4) m_car = 1'b1;
        if (in && m_phase != 6) m_ped = 1'b1;
        if (nxt == 3 && m_phase != 3) m_car = 1'b0;
        if (nxt == 6 && m_phase != 6) m_ped = 1'b0;
        m_el    = (nxt != m_phase) ? 0 : ((m_el < 1000) ? m_el + 1 : m_el);
        m_phase = nxt;
    endtask

    task automatic check_model(input string nm);
        chk({nm, " estado"}, int'(bus.Estado), m_phase);
        chk({nm, " lamps"}, int'(dut_lamps), int'(lamps_of(m_phase)));
        chk({nm, " peticion"}, int'(bus.Peticion_Pendiente), int'(m_ped));
    endtask

    task automatic tick(input bit in, input bit sen);
        bus.IN     = in;
        bus.Sensor = sen;
        @(posedge clk);
        model_step(in, sen);
        #1;
    endtask

    // Asserts reset between edges and checks outputs before any clock edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst estado", int'(bus.Estado), 0);
        chk("rst lamps", int'(dut_lamps), int'(7'b0011000));
        chk("rst peticion", int'(bus.Peticion_Pendiente), 0);
        @(posedge clk);
        #3;
        rst        = 1'b0;
        bus.IN     = 1'b0;
        bus.Sensor = 1'b0;
        model_reset();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        async_reset();
    endtask

    task automatic run_scen(input int s, input bit skip_reset);
        int c;
        bit in, sen;
        if (!skip_reset) apply_reset();
        c = 0;
        foreach (segs[i]) begin
            if (segs[i].scen == s) begin
                for (int k = 0; k < segs[i].len; k++) begin
                    in  = (c == in_cyc[s]);
                    sen = (c == sen_cyc[s]);
                    chk("seq estado", int'(bus.Estado), segs[i].estado);
                    chk("seq lamps", int'(dut_lamps), int'(lamps_of(segs[i].estado)));
                    chk("seq peticion", int'(bus.Peticion_Pendiente), int'(m_ped));
                    tick(in, sen);
                    c++;
                end
            end
        end
    endtask

    initial begin
        int walks;
        rst        = 1'b1;
        bus.IN     = 1'b0;
        bus.Sensor = 1'b0;
        model_reset();

        // Expected phase sequences: 0 car only, 1 pedestrian only, 2 both.
        segs.push_back('{0, 0, 8}); segs.push_back('{0, 1, 3}); segs.push_back('{0, 2, 1});
        segs.push_back('{0, 3, 8}); segs.push_back('{0, 4, 3}); segs.push_back('{0, 5, 1});
        segs.push_back('{0, 0, 4});
        segs.push_back('{1, 0, 8}); segs.push_back('{1, 1, 3}); segs.push_back('{1, 2, 1});
        segs.push_back('{1, 6, 6}); segs.push_back('{1, 0, 4});
        segs.push_back('{2, 0, 8}); segs.push_back('{2, 1, 3}); segs.push_back('{2, 2, 1});
        segs.push_back('{2, 6, 6}); segs.push_back('{2, 3, 8}); segs.push_back('{2, 4, 3});
        segs.push_back('{2, 5, 1}); segs.push_back('{2, 0, 4});
        in_cyc  = '{-1, 1, 1};
        sen_cyc = '{2, -1, 1};

        // Idle after reset: stays in VERDE_A.
        apply_reset();
        for (int c = 0; c < 50; c++) begin
            chk("idle estado", int'(bus.Estado), 0);
            tick(1'b0, 1'b0);
        end

        for (int s = 0; s < 3; s++) run_scen(s, 1'b0);

        // Pedestrian request visible the next cycle.
        apply_reset();
        chk("ped c0 peticion", int'(bus.Peticion_Pendiente), 0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk("ped c2 peticion", int'(bus.Peticion_Pendiente), 1);

        // IN held through PEATON and into the first VERDE_A cycle after it.
        apply_reset();
        walks = 0;
        for (int c = 0; c < 26; c++) begin
            check_model("hold");
            if (bus.Pasar_Persona) walks++;
            if (c == 18) chk("hold c18 peticion", int'(bus.Peticion_Pendiente), 0);
            if (c == 19) chk("hold c19 peticion", int'(bus.Peticion_Pendiente), 1);
            tick((c >= 1 && c <= 18), 1'b0);
        end
        chk("hold walk cycles", walks, 6);

        // Reset at the 4th VERDE_B cycle with a pedestrian request pending.
        apply_reset();
        for (int c = 0; c < 15; c++) begin
            check_model("midrst");
            tick((c == 13), (c == 2));
        end
        chk("midrst pre estado", int'(bus.Estado), 3);
        chk("midrst pre peticion", int'(bus.Peticion_Pendiente), 1);
        async_reset();
        run_scen(0, 1'b1);

        // Random requests with occasional resets against the model.
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            check_model("rand");
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                tick(($urandom_range(0, 24) == 0), ($urandom_range(0, 17) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
